// File: rtl/trail_occupancy_checker.sv
// Move-request responder for the Tron trail: checks a 160x120 occupancy bitmap, returns hit/clear, plots trail pixels.
// Optional build macro TRAIL_BORDER_WALL_EN makes the screen border solid and draws it white during the clear sweep.
module trail_occupancy_checker #(
  parameter int unsigned X_SIZE    = 160,
  parameter int unsigned Y_SIZE    = 120,
  parameter logic [2:0]  P0_COLOUR = 3'b101,
  parameter logic [2:0]  P1_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic       req_player,
  output logic       resp_valid,
  output logic       resp_hit,
  output logic       resp_player,
  output logic       plot,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [2:0] plot_colour,
  input  logic       clear_start,
  output logic       clear_busy
);

  localparam int unsigned DEPTH  = X_SIZE * Y_SIZE;
  localparam int unsigned AW     = 15;
  localparam logic [7:0]  X_LAST = 8'(X_SIZE - 1);
  localparam logic [6:0]  Y_LAST = 7'(Y_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CHECK, S_WRITE, S_CLEAR} state_t;

  state_t          r_state;
  logic            r_ready;
  logic            r_resp_valid;
  logic            r_resp_hit;
  logic            r_resp_player;
  logic            r_plot;
  logic [7:0]      r_plot_x;
  logic [6:0]      r_plot_y;
  logic [2:0]      r_plot_colour;
  logic            r_busy;
  logic [7:0]      r_x;
  logic [6:0]      r_y;
  logic            r_player;
  logic [7:0]      r_cx;
  logic [6:0]      r_cy;
  logic            r_mem [DEPTH];
  logic            r_ram_q;

  state_t          w_state_nxt;
  logic            w_ready_nxt;
  logic            w_resp_valid_nxt;
  logic            w_resp_hit_nxt;
  logic            w_resp_player_nxt;
  logic            w_plot_nxt;
  logic [7:0]      w_plot_x_nxt;
  logic [6:0]      w_plot_y_nxt;
  logic [2:0]      w_plot_colour_nxt;
  logic            w_busy_nxt;
  logic [7:0]      w_cx_nxt;
  logic [6:0]      w_cy_nxt;
  logic            w_accept;
  logic            w_we;
  logic            w_wdata;
  logic [AW-1:0]   w_addr;
  logic            w_oob;
  logic            w_hit;

  // y*160 + x without a multiplier
  function automatic logic [AW-1:0] f_addr(input logic [7:0] x, input logic [6:0] y);
    return (AW'(y) << 7) + (AW'(y) << 5) + AW'(x);
  endfunction

`ifdef TRAIL_BORDER_WALL_EN
  function automatic logic f_border(input logic [7:0] x, input logic [6:0] y);
    return (x == 8'd0) || (x == X_LAST) || (y == 7'd0) || (y == Y_LAST);
  endfunction
`endif

  assign w_oob = (r_x > X_LAST) || (r_y > Y_LAST);
`ifdef TRAIL_BORDER_WALL_EN
  assign w_hit = w_oob | f_border(r_x, r_y) | r_ram_q;
`else
  assign w_hit = w_oob | r_ram_q;
`endif

  // Next state and next registered outputs; the RAM is read in IDLE so the bit is ready by CHECK entry
  always_comb begin
    w_state_nxt       = r_state;
    w_ready_nxt       = 1'b0;
    w_resp_valid_nxt  = 1'b0;
    w_resp_hit_nxt    = r_resp_hit;
    w_resp_player_nxt = r_resp_player;
    w_plot_nxt        = 1'b0;
    w_plot_x_nxt      = r_plot_x;
    w_plot_y_nxt      = r_plot_y;
    w_plot_colour_nxt = r_plot_colour;
    w_busy_nxt        = 1'b0;
    w_cx_nxt          = r_cx;
    w_cy_nxt          = r_cy;
    w_accept          = 1'b0;
    w_we              = 1'b0;
    w_wdata           = 1'b0;
    w_addr            = f_addr(r_x, r_y);
    case (r_state)
      S_IDLE: begin
        w_addr      = f_addr(req_x, req_y);
        w_ready_nxt = 1'b1;
        if (clear_start) begin
          w_state_nxt  = S_CLEAR;
          w_ready_nxt  = 1'b0;
          w_busy_nxt   = 1'b1;
          w_plot_nxt   = 1'b1;
          w_cx_nxt     = 8'd0;
          w_cy_nxt     = 7'd0;
          w_plot_x_nxt = 8'd0;
          w_plot_y_nxt = 7'd0;
`ifdef TRAIL_BORDER_WALL_EN
          w_plot_colour_nxt = 3'b111;
`else
          w_plot_colour_nxt = 3'b000;
`endif
        end else if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_READ;
          w_ready_nxt = 1'b0;
        end
      end
      S_READ: begin
        w_state_nxt       = S_CHECK;
        w_resp_valid_nxt  = 1'b1;
        w_resp_hit_nxt    = w_hit;
        w_resp_player_nxt = r_player;
      end
      S_CHECK: begin
        if (r_resp_hit) begin
          w_state_nxt = S_IDLE;
          w_ready_nxt = 1'b1;
        end else begin
          w_state_nxt       = S_WRITE;
          w_plot_nxt        = 1'b1;
          w_plot_x_nxt      = r_x;
          w_plot_y_nxt      = r_y;
          w_plot_colour_nxt = r_player ? P1_COLOUR : P0_COLOUR;
        end
      end
      S_WRITE: begin
        w_we        = 1'b1;
        w_wdata     = 1'b1;
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
      S_CLEAR: begin
        w_addr  = f_addr(r_cx, r_cy);
        w_we    = 1'b1;
        w_wdata = 1'b0;
        if ((r_cx == X_LAST) && (r_cy == Y_LAST)) begin
          w_state_nxt = S_IDLE;
          w_ready_nxt = 1'b1;
        end else begin
          if (r_cx == X_LAST) begin
            w_cx_nxt = 8'd0;
            w_cy_nxt = r_cy + 7'd1;
          end else begin
            w_cx_nxt = r_cx + 8'd1;
          end
          w_busy_nxt   = 1'b1;
          w_plot_nxt   = 1'b1;
          w_plot_x_nxt = w_cx_nxt;
          w_plot_y_nxt = w_cy_nxt;
`ifdef TRAIL_BORDER_WALL_EN
          w_plot_colour_nxt = f_border(w_cx_nxt, w_cy_nxt) ? 3'b111 : 3'b000;
`else
          w_plot_colour_nxt = 3'b000;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_hit    <= 1'b0;
      r_resp_player <= 1'b0;
      r_plot        <= 1'b0;
      r_plot_x      <= 8'd0;
      r_plot_y      <= 7'd0;
      r_plot_colour <= 3'b000;
      r_busy        <= 1'b0;
      r_x           <= 8'd0;
      r_y           <= 7'd0;
      r_player      <= 1'b0;
      r_cx          <= 8'd0;
      r_cy          <= 7'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_ready       <= w_ready_nxt;
      r_resp_valid  <= w_resp_valid_nxt;
      r_resp_hit    <= w_resp_hit_nxt;
      r_resp_player <= w_resp_player_nxt;
      r_plot        <= w_plot_nxt;
      r_plot_x      <= w_plot_x_nxt;
      r_plot_y      <= w_plot_y_nxt;
      r_plot_colour <= w_plot_colour_nxt;
      r_busy        <= w_busy_nxt;
      r_cx          <= w_cx_nxt;
      r_cy          <= w_cy_nxt;
      if (w_accept) begin
        r_x      <= req_x;
        r_y      <= req_y;
        r_player <= req_player;
      end
    end
  end

  // Single-port occupancy RAM, read-first, no reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
    r_ram_q <= r_mem[w_addr];
  end

  // A same-cycle clear_start wins over a request, so readiness drops with it
  assign req_ready   = r_ready & ~clear_start;
  assign resp_valid  = r_resp_valid;
  assign resp_hit    = r_resp_hit;
  assign resp_player = r_resp_player;
  assign plot        = r_plot;
  assign plot_x      = r_plot_x;
  assign plot_y      = r_plot_y;
  assign plot_colour = r_plot_colour;
  assign clear_busy  = r_busy;

endmodule

// File: tb/tb_trail_occupancy_checker.sv
// Randomized self-checking bench for trail_occupancy_checker against a cell-array model of the playfield.
module tb_trail_occupancy_checker;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_x = 8'd0;
  logic [6:0] req_y = 7'd0;
  logic       req_player = 1'b0;
  logic       resp_valid;
  logic       resp_hit;
  logic       resp_player;
  logic       plot;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       clear_start = 1'b0;
  logic       clear_busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          bm [160][120];

  always #5 clk = ~clk;

  trail_occupancy_checker dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_player(req_player),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_player(resp_player),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .clear_start(clear_start), .clear_busy(clear_busy)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input int x, input int y);
    if (x >= 160 || y >= 120) return 1'b1;
`ifdef TRAIL_BORDER_WALL_EN
    if (x == 0 || x == 159 || y == 0 || y == 119) return 1'b1;
`endif
    return bm[x][y];
  endfunction

  function automatic int unsigned clr_colour(input int x, input int y);
`ifdef TRAIL_BORDER_WALL_EN
    if (x == 0 || x == 159 || y == 0 || y == 119) return 7;
`endif
    if (x < 0 || y < 0) return 1;
    return 0;
  endfunction

  // Issue one request from a negedge; checks latency, response and plot
  task automatic do_req(input int x, input int y, input bit p);
    bit eh;
    int w;
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("req_ready_wait", 0, 1);
      return;
    end
    eh         = model_hit(x, y);
    req_x      = 8'(x);
    req_y      = 7'(y);
    req_player = p;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("resp_valid_t1", resp_valid, 0);
    @(negedge clk);
    chk("resp_valid_t2", resp_valid, 1);
    chk("resp_hit", resp_hit, eh);
    chk("resp_player", resp_player, p);
    @(negedge clk);
    chk("plot_t3", plot, !eh);
    chk("ready_t3", req_ready, eh);
    if (!eh) begin
      chk("plot_x", plot_x, x);
      chk("plot_y", plot_y, y);
      chk("plot_colour", plot_colour, p ? 2 : 5);
      bm[x][y] = 1'b1;
      @(negedge clk);
      chk("plot_t4", plot, 0);
      chk("ready_t4", req_ready, 1);
    end
  endtask

  // Full sweep from a negedge in IDLE; optionally holds a competing request
  task automatic do_clear(input bit with_req);
    int cyc, nplot, nbad, nrdy, ex, ey;
    int unsigned lx, ly;
    clear_start = 1'b1;
    if (with_req) begin
      req_x = 8'd10; req_y = 7'd20; req_player = 1'b0; req_valid = 1'b1;
    end
    #1;
    chk("ready_at_clear_start", req_ready, 0);
    @(negedge clk);
    clear_start = 1'b0;
    cyc = 0; nplot = 0; nbad = 0; nrdy = 0; lx = 0; ly = 0;
    while (clear_busy && cyc < 20000) begin
      ex = cyc % 160;
      ey = cyc / 160;
      if (plot) nplot++;
      if (plot_x !== 8'(ex) || plot_y !== 7'(ey) || 32'(plot_colour) !== clr_colour(ex, ey)) nbad++;
      if (req_ready) nrdy++;
      lx = plot_x;
      ly = plot_y;
      clear_start = (cyc == 100);
      if (cyc == 19100) req_valid = 1'b0;
      cyc++;
      @(negedge clk);
    end
    clear_start = 1'b0;
    req_valid   = 1'b0;
    chk("clear_cycles", cyc, 19200);
    chk("clear_plots", nplot, 19200);
    chk("clear_bad_pixels", nbad, 0);
    chk("clear_ready_during", nrdy, 0);
    chk("clear_last_x", lx, 159);
    chk("clear_last_y", ly, 119);
    chk("after_clear_busy", clear_busy, 0);
    chk("after_clear_plot", plot, 0);
    chk("after_clear_ready", req_ready, 1);
    chk("after_clear_resp", resp_valid, 0);
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++)
        bm[i][j] = 1'b0;
  endtask

  task automatic rand_reqs(input int n);
    int x, y;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(1, 0) == 1) begin
        x = $urandom_range(11, 8);
        y = $urandom_range(11, 8);
      end else begin
        x = $urandom_range(169, 0);
        y = $urandom_range(127, 0);
      end
      do_req(x, y, 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_plot", plot, 0);
    chk("rst_plot_x", plot_x, 0);
    chk("rst_plot_y", plot_y, 0);
    chk("rst_plot_colour", plot_colour, 0);
    chk("rst_clear_busy", clear_busy, 0);
    resetn = 1'b1;
    @(negedge clk);

    do_clear(1'b0);
    do_req(10, 20, 1'b0);
    do_req(10, 20, 1'b1);
    do_req(160, 5, 1'b0);
    do_req(5, 120, 1'b1);
    do_req(159, 119, 1'b0);
    do_req(0, 6, 1'b0);

    do_clear(1'b1);
    do_req(10, 20, 1'b0);
    rand_reqs(150);

    // Reset part-way through a sweep
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (500) @(negedge clk);
    chk("mid_sweep_busy", clear_busy, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", clear_busy, 0);
    chk("mid_rst_plot", plot, 0);
    chk("mid_rst_plot_x", plot_x, 0);
    chk("mid_rst_plot_y", plot_y, 0);
    chk("mid_rst_colour", plot_colour, 0);
    chk("mid_rst_ready", req_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", clear_busy, 0);
    chk("post_rst_plot", plot, 0);
    chk("post_rst_ready", req_ready, 1);

    do_clear(1'b0);
    do_req(10, 20, 1'b1);
    rand_reqs(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trail_occupancy_checker.md
Name: trail_occupancy_checker

Overview:
- Responder side of the player-move interface in the Tron game.
- Each player movement unit issues a move request (x, y, player).
- The block checks the target cell against an internal 160x120 occupancy bitmap and the screen bounds, and returns hit/clear.
- On a clear result it marks the cell occupied and issues a single-pixel plot command (x, y, colour, plot) toward the vga_adapter path. A clear sweep empties the bitmap and blanks the screen between rounds.

Parameters:
- X_SIZE, 160, screen width in cells.
- Y_SIZE, 120, screen height in cells.
- P0_COLOUR, 3'b101, trail colour for player 0.
- P1_COLOUR, 3'b010, trail colour for player 1.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  1  move request present.
- req_ready  output  1  block can accept a request.
- req_x  input  8  target x.
- req_y  input  7  target y.
- req_player  input  1  0 = player 0, 1 = player 1.
- resp_valid  output  1  one-cycle pulse; resp_hit and resp_player are valid.
- resp_hit  output  1  1 = collision (occupied or out of bounds).
- resp_player  output  1  player the response belongs to.
- plot  output  1  one-cycle pixel write strobe.
- plot_x  output  8  pixel x.
- plot_y  output  7  pixel y.
- plot_colour  output  3  pixel colour.
- clear_start  input  1  start clear sweep.
- clear_busy  output  1  sweep in progress.

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0 except req_ready=1; plot_x/plot_y/plot_colour = 0. Bitmap contents are undefined after reset; software issues clear_start before the first round.
- Bitmap: X_SIZE*Y_SIZE x 1-bit synchronous RAM, one read/write port, read latency 1. Address = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits wide.
- States: IDLE, READ, CHECK, WRITE, CLEAR.
- IDLE: req_ready=1.
  - If clear_start=1: go to CLEAR. clear_start has priority over req_valid; req_ready=0 in that cycle.
  - Else if req_valid=1: latch x/y/player and go to READ.
- READ: present the address to the RAM; req_ready=0.
- CHECK: RAM data is available.
  - resp_hit = out_of_bounds OR bit, where out_of_bounds = x>=X_SIZE or y>=Y_SIZE. On out of bounds the RAM data is ignored.
  - resp_valid=1 for exactly this cycle.
  - If hit: go to IDLE. Else: go to WRITE.
- WRITE: write bit=1 at the address; plot=1 for one cycle; plot_x/plot_y = the latched coordinates; plot_colour = P0_COLOUR or P1_COLOUR by player; then go to IDLE.
- Latency: accept at cycle T; resp_valid at T+2; plot at T+3. Next accept is possible at T+3 after a hit, or T+4 after a miss.
- CLEAR: counter steps x 0..159 inner, y 0..119 outer, one cell per cycle.
  - Each cycle: write bit=0, plot=1, plot_colour=3'b000.
  - clear_busy=1 throughout; req_ready=0.
  - After cell (159,119), return to IDLE. Total 19200 cycles.
- clear_start while not in IDLE is ignored.
- Outputs plot_x/plot_y/plot_colour hold their last value when plot=0.
- Two requests to the same cell back-to-back: the second sees bit=1 (the write completes before the next READ) → hit.
- Reset mid-sweep or mid-request: immediate return to IDLE. Bitmap is partially written and treated as undefined.

Optional Feature:
- Macro: TRAIL_BORDER_WALL_EN.
- Defined:
  - Cells with x==0, x==X_SIZE-1, y==0 or y==Y_SIZE-1 report hit regardless of bitmap contents.
  - The clear sweep plots border cells with colour 3'b111 and interior cells with 3'b000.
- Undefined:
  - Only coordinates outside the bounds hit.
  - The sweep plots every cell 3'b000.

Test Plan:
- resetn low, then high; clear_start pulse → clear_busy=1 for 19200 cycles; 19200 plot pulses with colour 000; last plot at (159,119); req_ready=1 afterwards.
- After clear: request (10,20,player0) → resp_valid at T+2 with hit=0, resp_player=0; plot at T+3 at (10,20) with colour 101.
- Repeat request (10,20,player1) → hit=1, resp_player=1, no plot pulse.
- Request (160,5) and request (5,120) → hit=1, no RAM write, no plot; a later request (159,119) → hit=0 when the macro is undefined, hit=1 when TRAIL_BORDER_WALL_EN is defined.
- clear_start and req_valid asserted together in IDLE → CLEAR entered; request not accepted (req_ready=0) until the sweep ends; a following request to (10,20) → hit=0.
- resetn pulsed low at sweep cycle 500 → outputs return to reset values at once; state IDLE; req_ready=1.
